// File: rtl/reg_forward_unit.sv
// Operand forwarding with load-use and long-latency (mult/div) hazard detection.
// Optional stall-cycle counter is built when REG_FWD_STALL_CNT_EN is defined.
module reg_forward_unit #(
  parameter int DATA_W   = 32,
  parameter int NUM_RD   = 2,
  parameter int LONG_LAT = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*5-1:0]        rd_addr,
  input  logic [NUM_RD*DATA_W-1:0]   rf_data,
  input  logic                       ex_we,
  input  logic [4:0]                 ex_waddr,
  input  logic [DATA_W-1:0]          ex_wdata,
  input  logic                       ex_is_load,
  input  logic                       mem_we,
  input  logic [4:0]                 mem_waddr,
  input  logic [DATA_W-1:0]          mem_wdata,
  input  logic                       long_issue,
  input  logic [4:0]                 long_waddr,
  input  logic                       flush,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic                       stall,
  output logic                       long_busy,
  output logic [31:0]                stall_cnt
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] BUSY     = 1'b1;
  localparam logic [3:0] LAT_LOAD = 4'(LONG_LAT - 1);

  logic [0:0]        state;
  logic [3:0]        cnt;
  logic [4:0]        busy_addr;
  logic              busy;
  logic [NUM_RD-1:0] load_hit;
  logic [NUM_RD-1:0] busy_hit;

  assign busy      = (state == BUSY);
  assign long_busy = busy;

  // Per-port resolution: a load in EX has no data yet, so it is skipped and
  // the port falls through to MEM/RF while the load-use stall holds ID.
  for (genvar g = 0; g < NUM_RD; g++) begin : g_port
    logic [4:0] addr;
    logic       live;
    logic       ex_hit;
    logic       mem_hit;

    assign addr    = rd_addr[5*g +: 5];
    assign live    = rd_en[g] && (addr != 5'd0);
    assign ex_hit  = ex_we && !ex_is_load && (ex_waddr == addr);
    assign mem_hit = mem_we && (mem_waddr == addr);

    assign rd_data[DATA_W*g +: DATA_W] = !live   ? '0 :
                                         ex_hit  ? ex_wdata :
                                         mem_hit ? mem_wdata :
                                                   rf_data[DATA_W*g +: DATA_W];

    assign load_hit[g] = live && ex_we && ex_is_load && (ex_waddr == addr);
    assign busy_hit[g] = live && busy && (busy_addr == addr);
  end

  // Only one long unit exists, so a second issue while busy is a structural hazard.
  assign stall = (|load_hit) || (|busy_hit) || (busy && long_issue);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      busy_addr <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // r0 results are discarded, so such an issue needs no tracking.
          if (long_issue && !stall && (long_waddr != 5'd0)) begin
            state     <= BUSY;
            busy_addr <= long_waddr;
            cnt       <= LAT_LOAD;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) state <= IDLE;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef REG_FWD_STALL_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)     stall_cnt_q <= '0;
    else if (stall) stall_cnt_q <= sat_inc(stall_cnt_q);
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_reg_forward_unit.sv
// Scoreboard bench for reg_forward_unit (default parameters, LONG_LAT=4).
module tb_reg_forward_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rf_data;
  logic        ex_we;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        ex_is_load;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        long_issue;
  logic [4:0]  long_waddr;
  logic        flush;
  logic [63:0] rd_data;
  logic        stall;
  logic        long_busy;
  logic [31:0] stall_cnt;

  reg_forward_unit #(.DATA_W(32), .NUM_RD(2), .LONG_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rf_data(rf_data),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .long_issue(long_issue), .long_waddr(long_waddr), .flush(flush),
    .rd_data(rd_data), .stall(stall), .long_busy(long_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d0;
    logic [31:0] d1;
    logic        st;
    logic        bz;
    logic [31:0] sc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  int    model_cnt = 0;

  localparam logic [31:0] RF0 = 32'h0000_00AA;
  localparam logic [31:0] RF1 = 32'h0000_00BB;

  task automatic clr();
    rst_n = 1'b1; rd_en = '0; rd_addr = '0; rf_data = {RF1, RF0};
    ex_we = 0; ex_waddr = 0; ex_wdata = 32'h11; ex_is_load = 0;
    mem_we = 0; mem_waddr = 0; mem_wdata = 32'h22;
    long_issue = 0; long_waddr = 0; flush = 0;
  endtask

  task automatic push(input string nm, input logic [31:0] d0, input logic [31:0] d1,
                      input logic st, input logic bz);
    exp_t e;
    e.d0 = d0; e.d1 = d1; e.st = st; e.bz = bz;
`ifdef REG_FWD_STALL_CNT_EN
    e.sc = model_cnt;
`else
    e.sc = 32'd0;
`endif
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Reference stall counter follows the stall level expected in this cycle.
  task automatic next_cycle(input logic st);
    if (!rst_n) model_cnt = 0;
    else if (st) model_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    exp_t e; string nm;
    for (int c = 0; c < 3; c++) begin
      clr(); rst_n = 0; flush = 1; long_issue = 1; long_waddr = 5'd9;
      rd_en = 2'b11; rd_addr = {5'd0, 5'd9};
      push("reset", RF0, 0, 0, 0);
      @(negedge clk);
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if ({rd_data, stall, long_busy, stall_cnt} !== {e.d1, e.d0, e.st, e.bz, e.sc}) begin
        errors++;
        $display("FAIL %s c%0d: rd_data=%h stall=%b busy=%b cnt=%0d required rd_data=%h stall=%b busy=%b cnt=%0d",
                 nm, c, rd_data, stall, long_busy, stall_cnt, {e.d1, e.d0}, e.st, e.bz, e.sc);
      end
      next_cycle(e.st);
    end
    clr();
  endtask

  task automatic test_forward();
    exp_t e; string nm;
    for (int c = 0; c < 6; c++) begin
      clr();
      ex_we = 1; ex_waddr = 5; mem_we = 1; mem_waddr = 5;
      rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
      case (c)
        0: push("fwd_ex_prio", 32'h11, 0, 0, 0);
        1: begin ex_we = 0; push("fwd_mem", 32'h22, 0, 0, 0); end
        2: begin ex_waddr = 7; mem_waddr = 6; push("fwd_rf", RF0, 0, 0, 0); end
        3: begin
          ex_is_load = 1; rd_en = 2'b11; rd_addr = {5'd5, 5'd5};
          push("fwd_load_skip", 32'h22, 32'h22, 1, 0);
        end
        4: begin
          ex_waddr = 0; mem_waddr = 0; ex_is_load = 1; rd_en = 2'b11; rd_addr = '0;
          push("fwd_r0", 0, 0, 0, 0);
        end
        default: begin rd_en = 2'b00; rd_addr = {5'd5, 5'd5}; push("fwd_disabled", 0, 0, 0, 0); end
      endcase
      @(negedge clk);
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if ({rd_data, stall, long_busy, stall_cnt} !== {e.d1, e.d0, e.st, e.bz, e.sc}) begin
        errors++;
        $display("FAIL %s c%0d: rd_data=%h stall=%b busy=%b cnt=%0d required rd_data=%h stall=%b busy=%b cnt=%0d",
                 nm, c, rd_data, stall, long_busy, stall_cnt, {e.d1, e.d0}, e.st, e.bz, e.sc);
      end
      next_cycle(e.st);
    end
    clr();
  endtask

  task automatic test_load_use();
    exp_t e; string nm;
    for (int c = 0; c < 3; c++) begin
      clr();
      ex_is_load = 1; ex_we = 1; ex_waddr = 8; rd_en = 2'b10; rd_addr = {5'd8, 5'd0};
      case (c)
        0: push("load_use", 0, RF1, 1, 0);
        1: begin rd_addr = {5'd0, 5'd0}; push("load_use_r0", 0, 0, 0, 0); end
        default: begin ex_we = 0; push("load_no_we", 0, RF1, 0, 0); end
      endcase
      @(negedge clk);
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if ({rd_data, stall, long_busy, stall_cnt} !== {e.d1, e.d0, e.st, e.bz, e.sc}) begin
        errors++;
        $display("FAIL %s c%0d: rd_data=%h stall=%b busy=%b cnt=%0d required rd_data=%h stall=%b busy=%b cnt=%0d",
                 nm, c, rd_data, stall, long_busy, stall_cnt, {e.d1, e.d0}, e.st, e.bz, e.sc);
      end
      next_cycle(e.st);
    end
    clr();
  endtask

  task automatic test_long_op();
    exp_t e; string nm;
    for (int c = 0; c < 6; c++) begin
      clr();
      if (c == 0) begin
        long_issue = 1; long_waddr = 9;
        push("long_issue", 0, 0, 0, 0);
      end else begin
        rd_en = 2'b01; rd_addr = {5'd0, 5'd9};
        if (c <= 4) push("long_busy_read", RF0, 0, 1, 1);
        else        push("long_done", RF0, 0, 0, 0);
      end
      @(negedge clk);
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if ({rd_data, stall, long_busy, stall_cnt} !== {e.d1, e.d0, e.st, e.bz, e.sc}) begin
        errors++;
        $display("FAIL %s c%0d: rd_data=%h stall=%b busy=%b cnt=%0d required rd_data=%h stall=%b busy=%b cnt=%0d",
                 nm, c, rd_data, stall, long_busy, stall_cnt, {e.d1, e.d0}, e.st, e.bz, e.sc);
      end
      next_cycle(e.st);
    end
    clr();
  endtask

  task automatic test_structural();
    exp_t e; string nm;
    for (int c = 0; c < 7; c++) begin
      clr();
      case (c)
        0: begin long_issue = 1; long_waddr = 3; push("struct_issue", 0, 0, 0, 0); end
        1: begin long_issue = 1; long_waddr = 4; push("struct_hazard", 0, 0, 1, 1); end
        2: begin rd_en = 2'b10; rd_addr = {5'd3, 5'd0}; push("struct_read_busy", 0, RF1, 1, 1); end
        3, 4: push("struct_busy_idle_in", 0, 0, 0, 1);
        5: push("struct_done", 0, 0, 0, 0);
        default: begin rd_en = 2'b01; rd_addr = {5'd0, 5'd4}; push("struct_rejected", RF0, 0, 0, 0); end
      endcase
      @(negedge clk);
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if ({rd_data, stall, long_busy, stall_cnt} !== {e.d1, e.d0, e.st, e.bz, e.sc}) begin
        errors++;
        $display("FAIL %s c%0d: rd_data=%h stall=%b busy=%b cnt=%0d required rd_data=%h stall=%b busy=%b cnt=%0d",
                 nm, c, rd_data, stall, long_busy, stall_cnt, {e.d1, e.d0}, e.st, e.bz, e.sc);
      end
      next_cycle(e.st);
    end
    clr();
  endtask

  task automatic test_flush();
    exp_t e; string nm;
    for (int c = 0; c < 6; c++) begin
      clr();
      case (c)
        0: begin long_issue = 1; long_waddr = 9; push("flush_issue", 0, 0, 0, 0); end
        1: push("flush_busy", 0, 0, 0, 1);
        2: begin flush = 1; push("flush_asserted", 0, 0, 0, 1); end
        3: begin rd_en = 2'b01; rd_addr = {5'd0, 5'd9}; push("flush_cleared", RF0, 0, 0, 0); end
        4: begin long_issue = 1; long_waddr = 9; flush = 1; push("flush_vs_issue", 0, 0, 0, 0); end
        default: begin rd_en = 2'b01; rd_addr = {5'd0, 5'd9}; push("flush_issue_dropped", RF0, 0, 0, 0); end
      endcase
      @(negedge clk);
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if ({rd_data, stall, long_busy, stall_cnt} !== {e.d1, e.d0, e.st, e.bz, e.sc}) begin
        errors++;
        $display("FAIL %s c%0d: rd_data=%h stall=%b busy=%b cnt=%0d required rd_data=%h stall=%b busy=%b cnt=%0d",
                 nm, c, rd_data, stall, long_busy, stall_cnt, {e.d1, e.d0}, e.st, e.bz, e.sc);
      end
      next_cycle(e.st);
    end
    clr();
  endtask

  task automatic test_zero_issue();
    exp_t e; string nm;
    for (int c = 0; c < 2; c++) begin
      clr();
      if (c == 0) begin
        long_issue = 1; long_waddr = 0; push("zero_issue", 0, 0, 0, 0);
      end else begin
        ex_we = 1; ex_is_load = 1; ex_waddr = 0; rd_en = 2'b11; rd_addr = '0;
        push("zero_stays_idle", 0, 0, 0, 0);
      end
      @(negedge clk);
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if ({rd_data, stall, long_busy, stall_cnt} !== {e.d1, e.d0, e.st, e.bz, e.sc}) begin
        errors++;
        $display("FAIL %s c%0d: rd_data=%h stall=%b busy=%b cnt=%0d required rd_data=%h stall=%b busy=%b cnt=%0d",
                 nm, c, rd_data, stall, long_busy, stall_cnt, {e.d1, e.d0}, e.st, e.bz, e.sc);
      end
      next_cycle(e.st);
    end
    clr();
  endtask

  task automatic test_back_to_back();
    exp_t e; string nm;
    for (int c = 0; c < 13; c++) begin
      clr();
      case (c)
        0: begin long_issue = 1; long_waddr = 5; push("b2b_issue_a", 0, 0, 0, 0); end
        1, 2, 3: push("b2b_busy_a", 0, 0, 0, 1);
        4: begin long_issue = 1; long_waddr = 6; push("b2b_last_busy_hazard", 0, 0, 1, 1); end
        5: begin long_issue = 1; long_waddr = 6; push("b2b_issue_b", 0, 0, 0, 0); end
        6: begin rd_en = 2'b01; rd_addr = {5'd0, 5'd6}; push("b2b_read_b", RF0, 0, 1, 1); end
        7, 8, 9: push("b2b_busy_b", 0, 0, 0, 1);
        10: push("b2b_done_b", 0, 0, 0, 0);
        11: begin
          long_issue = 1; long_waddr = 7; ex_we = 1; ex_is_load = 1; ex_waddr = 8;
          rd_en = 2'b10; rd_addr = {5'd8, 5'd0};
          push("b2b_issue_under_stall", 0, RF1, 1, 0);
        end
        default: push("b2b_issue_blocked", 0, 0, 0, 0);
      endcase
      @(negedge clk);
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if ({rd_data, stall, long_busy, stall_cnt} !== {e.d1, e.d0, e.st, e.bz, e.sc}) begin
        errors++;
        $display("FAIL %s c%0d: rd_data=%h stall=%b busy=%b cnt=%0d required rd_data=%h stall=%b busy=%b cnt=%0d",
                 nm, c, rd_data, stall, long_busy, stall_cnt, {e.d1, e.d0}, e.st, e.bz, e.sc);
      end
      next_cycle(e.st);
    end
    clr();
  endtask

  task automatic test_reset_mid_busy();
    exp_t e; string nm;
    for (int c = 0; c < 4; c++) begin
      clr();
      case (c)
        0: begin long_issue = 1; long_waddr = 9; push("rstmid_issue", 0, 0, 0, 0); end
        1: push("rstmid_busy", 0, 0, 0, 1);
        2: begin rst_n = 0; rd_en = 2'b01; rd_addr = {5'd0, 5'd9}; push("rstmid_in_reset", RF0, 0, 1, 1); end
        default: begin rd_en = 2'b01; rd_addr = {5'd0, 5'd9}; push("rstmid_after", RF0, 0, 0, 0); end
      endcase
      @(negedge clk);
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if ({rd_data, stall, long_busy, stall_cnt} !== {e.d1, e.d0, e.st, e.bz, e.sc}) begin
        errors++;
        $display("FAIL %s c%0d: rd_data=%h stall=%b busy=%b cnt=%0d required rd_data=%h stall=%b busy=%b cnt=%0d",
                 nm, c, rd_data, stall, long_busy, stall_cnt, {e.d1, e.d0}, e.st, e.bz, e.sc);
      end
      next_cycle(e.st);
    end
    clr();
  endtask

  task automatic test_stall_cnt();
    exp_t e; string nm;
    for (int c = 0; c < 7; c++) begin
      clr();
      case (c)
        0, 5: begin rst_n = 0; push("scnt_reset", 0, 0, 0, 0); end
        1, 2, 3: begin
          ex_we = 1; ex_is_load = 1; ex_waddr = 8; rd_en = 2'b01; rd_addr = {5'd0, 5'd8};
          push("scnt_stall", RF0, 0, 1, 0);
        end
        default: push("scnt_read", 0, 0, 0, 0);
      endcase
      @(negedge clk);
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if ({rd_data, stall, long_busy, stall_cnt} !== {e.d1, e.d0, e.st, e.bz, e.sc}) begin
        errors++;
        $display("FAIL %s c%0d: rd_data=%h stall=%b busy=%b cnt=%0d required rd_data=%h stall=%b busy=%b cnt=%0d",
                 nm, c, rd_data, stall, long_busy, stall_cnt, {e.d1, e.d0}, e.st, e.bz, e.sc);
      end
`ifdef REG_FWD_STALL_CNT_EN
      if (c == 4) begin
        checks++;
        if (stall_cnt !== 32'd3) begin
          errors++;
          $display("FAIL scnt_three: stall_cnt=%0d required 3", stall_cnt);
        end
      end
`endif
      next_cycle(e.st);
    end
    clr();
  endtask

  task automatic test_random_forward();
    exp_t e; string nm;
    logic [31:0] d[2];
    logic        st;
    for (int c = 0; c < 24; c++) begin
      clr();
      rd_en = 2'($urandom_range(0, 3));
      rd_addr = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      rf_data = {$urandom, $urandom};
      ex_we = 1'($urandom_range(0, 1)); ex_waddr = 5'($urandom_range(0, 3));
      ex_wdata = $urandom; ex_is_load = 1'($urandom_range(0, 1));
      mem_we = 1'($urandom_range(0, 1)); mem_waddr = 5'($urandom_range(0, 3));
      mem_wdata = $urandom;
      st = 0;
      for (int p = 0; p < 2; p++) begin
        logic [4:0] a;
        a = rd_addr[5*p +: 5];
        if (!rd_en[p] || a == 0) d[p] = 0;
        else begin
          if (ex_we && ex_waddr == a && ex_is_load) st = 1;
          if (ex_we && ex_waddr == a && !ex_is_load) d[p] = ex_wdata;
          else if (mem_we && mem_waddr == a)        d[p] = mem_wdata;
          else                                      d[p] = rf_data[32*p +: 32];
        end
      end
      push("rand_fwd", d[0], d[1], st, 0);
      @(negedge clk);
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if ({rd_data, stall, long_busy, stall_cnt} !== {e.d1, e.d0, e.st, e.bz, e.sc}) begin
        errors++;
        $display("FAIL %s c%0d: rd_data=%h stall=%b busy=%b cnt=%0d required rd_data=%h stall=%b busy=%b cnt=%0d",
                 nm, c, rd_data, stall, long_busy, stall_cnt, {e.d1, e.d0}, e.st, e.bz, e.sc);
      end
      next_cycle(e.st);
    end
    clr();
  endtask

  initial begin
    clr();
    rst_n = 0;
    @(posedge clk); #1;
    model_cnt = 0;
    test_reset();
    test_forward();
    test_load_use();
    test_long_op();
    test_structural();
    test_flush();
    test_zero_issue();
    test_back_to_back();
    test_reset_mid_busy();
    test_stall_cnt();
    test_random_forward();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
